// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and default width.
package serial_sub_pkg;

    localparam int unsigned SUB_DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } sub_state_e;

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor: d = x - y - bin, with borrow-out.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    always_comb begin
        d    = x ^ y ^ bin;
        bout = (~x & y) | (~(x ^ y) & bin);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (DIFF = A - B, LSB first) with start/busy/done handshake.
// Define SERIAL_SUB_OVF_EN to add the registered signed-overflow output OVF.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = SUB_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] DIFF,
`ifdef SERIAL_SUB_OVF_EN
    output logic             OVF,
`endif
    output logic             BOUT
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    sub_state_e       state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] r_sh_q, r_sh_d;
    logic             borrow_q, borrow_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
`ifdef SERIAL_SUB_OVF_EN
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic             ovf_q, ovf_d;
`endif

    logic             bit_d;
    logic             bit_bn;
    logic [WIDTH-1:0] r_next;

    full_subtractor u_fs (
        .x   (a_sh_q[0]),
        .y   (b_sh_q[0]),
        .bin (borrow_q),
        .d   (bit_d),
        .bout(bit_bn)
    );

    // Result bit enters at the MSB; after WIDTH shifts bit 0 of the result sits at the LSB.
    assign r_next = WIDTH'({bit_d, r_sh_q} >> 1);

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        r_sh_d   = r_sh_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        bout_d   = bout_q;
`ifdef SERIAL_SUB_OVF_EN
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        ovf_d    = ovf_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_sh_d   = A;
                    b_sh_d   = B;
                    r_sh_d   = '0;
                    borrow_d = 1'b0;
                    cnt_d    = '0;
`ifdef SERIAL_SUB_OVF_EN
                    a_msb_d  = A[WIDTH-1];
                    b_msb_d  = B[WIDTH-1];
`endif
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                r_sh_d   = r_next;
                borrow_d = bit_bn;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    diff_d  = r_next;
                    bout_d  = bit_bn;
`ifdef SERIAL_SUB_OVF_EN
                    ovf_d   = (a_msb_q ^ b_msb_q) & (bit_d ^ a_msb_q);
`endif
                    state_d = S_DONE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            r_sh_q   <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            r_sh_q   <= r_sh_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);
    assign DIFF = diff_q;
    assign BOUT = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    assign OVF  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=8), vector table plus handshake corner cases.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] A, B;
    logic         busy, done, BOUT;
    logic [W-1:0] DIFF;
`ifdef SERIAL_SUB_OVF_EN
    logic         OVF;
`endif

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .A    (A),
        .B    (B),
        .busy (busy),
        .done (done),
        .DIFF (DIFF),
`ifdef SERIAL_SUB_OVF_EN
        .OVF  (OVF),
`endif
        .BOUT (BOUT)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] diff;
        logic         bout;
        logic         ovf;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Launch one operation and wait (bounded) for done; lat = negedges after the accept edge.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
        @(negedge clk);
        A = a;
        B = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        A = W'($urandom);
        B = W'($urandom);
        chk("busy_after_accept", {31'b0, busy}, 32'd1);
        lat = 0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int lat;
        int n_done;
        int k;
        int t[3];

        vecs[0] = '{8'h05, 8'h03, 8'h02, 1'b0, 1'b0};
        vecs[1] = '{8'h03, 8'h05, 8'hFE, 1'b1, 1'b0};
        vecs[2] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[3] = '{8'hFF, 8'h01, 8'hFE, 1'b0, 1'b0};
        vecs[4] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
        vecs[5] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};

        rst = 1'b1;
        start = 1'b0;
        A = '0;
        B = '0;
        #12;
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_done", {31'b0, done}, 32'd0);
        chk("reset_diff", {24'b0, DIFF}, 32'd0);
        chk("reset_bout", {31'b0, BOUT}, 32'd0);
`ifdef SERIAL_SUB_OVF_EN
        chk("reset_ovf", {31'b0, OVF}, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, lat);
            chk("vec_latency", lat, W);
            chk("vec_diff", {24'b0, DIFF}, {24'b0, vecs[i].diff});
            chk("vec_bout", {31'b0, BOUT}, {31'b0, vecs[i].bout});
`ifdef SERIAL_SUB_OVF_EN
            chk("vec_ovf", {31'b0, OVF}, {31'b0, vecs[i].ovf});
`endif
            @(negedge clk);
            chk("done_one_cycle", {31'b0, done}, 32'd0);
            chk("idle_not_busy", {31'b0, busy}, 32'd0);
        end

        // start pulsed during RUN must be ignored
        @(negedge clk);
        A = 8'h05;
        B = 8'h03;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_done = 0;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            if (i == 3) begin
                start = 1'b1;
                A = 8'hAA;
                B = 8'h11;
            end
            if (i == 4) start = 1'b0;
            if (done) n_done++;
        end
        chk("ignored_start_done_count", n_done, 1);
        chk("ignored_start_diff", {24'b0, DIFF}, 32'h02);

        // reset mid-operation
        @(negedge clk);
        A = 8'h03;
        B = 8'h05;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        chk("midrst_done", {31'b0, done}, 32'd0);
        chk("midrst_diff", {24'b0, DIFF}, 32'd0);
        chk("midrst_bout", {31'b0, BOUT}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op(8'h10, 8'h01, lat);
        chk("post_rst_latency", lat, W);
        chk("post_rst_diff", {24'b0, DIFF}, 32'h0F);

        // start held high: back-to-back operations
        @(negedge clk);
        A = 8'h20;
        B = 8'h10;
        start = 1'b1;
        k = 0;
        for (int i = 0; i < 60 && k < 3; i++) begin
            @(negedge clk);
            if (done) begin
                t[k] = cyc;
                chk("b2b_diff", {24'b0, DIFF}, 32'h10);
                k++;
            end
        end
        start = 1'b0;
        chk("b2b_count", k, 3);
        if (k == 3) begin
            chk("b2b_gap01", t[1] - t[0], W + 2);
            chk("b2b_gap12", t[2] - t[1], W + 2);
        end

        repeat (12) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
